// File: rtl/cpu_chk_pkg.sv
// Shared types and index-map helpers for the end-of-program halt checker.
package cpu_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CAP_PC,
    ST_SCAN,
    ST_DONE
  } chk_state_e;

  // Unified index map: PC first, then data memory, then registers.
  localparam int IDX_PC = 0;

  function automatic int idx_mem_base();
    return 1;
  endfunction

  function automatic int idx_reg_base(input int mem_words);
    return 1 + mem_words;
  endfunction

  // Address width that never collapses to zero bits for single-entry spaces.
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chk_err_accum.sv
// Registers one compare per cycle, then accumulates a saturating mismatch
// count and latches the unified index of the first mismatch.
module chk_err_accum
  import cpu_chk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] actual_i,
  input  logic [DATA_W-1:0] expected_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic              first_err_valid_o,
  output logic [IDX_W-1:0]  first_err_idx_o
);

  logic             mis_q;
  logic [IDX_W-1:0] idx_q;
  logic [ERR_W-1:0] cnt_q;
  logic             fev_q;
  logic [IDX_W-1:0] fidx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      mis_q  <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
      fev_q  <= 1'b0;
      fidx_q <= '0;
    end else begin
      mis_q <= valid_i && (actual_i != expected_i);
      idx_q <= idx_i;
      if (mis_q) begin
        if (cnt_q != '1) cnt_q <= cnt_q + ERR_W'(1);
        if (!fev_q) begin
          fev_q  <= 1'b1;
          fidx_q <= idx_q;
        end
      end
    end
  end

  assign err_count_o       = cnt_q;
  assign first_err_valid_o = fev_q;
  assign first_err_idx_o   = fidx_q;

endmodule

// File: rtl/cpu_halt_checker.sv
// End-of-program checker: waits for the halt instruction, freezes the CPU,
// then streams PC, data memory and registers against an expected-value ROM.
module cpu_halt_checker
  import cpu_chk_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                MEM_WORDS   = 32,
  parameter int                REG_COUNT   = 32,
  parameter logic [DATA_W-1:0] HALT_INSTR  = 32'hFFFFFFFF,
  parameter int                TIMEOUT_CYC = 200,
  parameter int                ERR_W       = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic [DATA_W-1:0]                            instr_i,
  input  logic [DATA_W-1:0]                            pc_i,
  output logic                                         cpu_freeze_o,
  output logic [clog2w(MEM_WORDS)-1:0]                 mem_addr_o,
  input  logic [DATA_W-1:0]                            mem_data_i,
  output logic [clog2w(REG_COUNT)-1:0]                 reg_addr_o,
  input  logic [DATA_W-1:0]                            reg_data_i,
  output logic [clog2w(1+MEM_WORDS+REG_COUNT)-1:0]     exp_addr_o,
  input  logic [DATA_W-1:0]                            exp_data_i,
  output logic                                         done_o,
  output logic                                         pass_o,
  output logic                                         timeout_o,
  output logic [ERR_W-1:0]                             err_count_o,
  output logic                                         first_err_valid_o,
  output logic [clog2w(1+MEM_WORDS+REG_COUNT)-1:0]     first_err_idx_o,
  output chk_state_e                                   dbg_state_o
);

  localparam int N            = 1 + MEM_WORDS + REG_COUNT;
  localparam int IDX_W        = clog2w(N);
  localparam int MA_W         = clog2w(MEM_WORDS);
  localparam int RA_W         = clog2w(REG_COUNT);
  localparam int IDX_MEM_BASE = idx_mem_base();
  localparam int IDX_REG_BASE = idx_reg_base(MEM_WORDS);
  localparam int CNT_MAX      = (TIMEOUT_CYC > N + 2) ? TIMEOUT_CYC : N + 2;
  localparam int CNT_W        = clog2w(CNT_MAX + 1);

  chk_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              freeze_q, freeze_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              iss_valid_q, iss_valid_d;
  logic [IDX_W-1:0]  iss_idx_q, iss_idx_d;
  logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [RA_W-1:0]   reg_addr_q, reg_addr_d;
  logic [IDX_W-1:0]  exp_addr_q, exp_addr_d;
  logic              rd_valid_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic [DATA_W-1:0] actual;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    freeze_d    = freeze_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    pc_d        = pc_q;
    iss_valid_d = 1'b0;
    iss_idx_d   = iss_idx_q;
    mem_addr_d  = '0;
    reg_addr_d  = '0;
    exp_addr_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!start_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (instr_i == HALT_INSTR) begin
          state_d  = ST_CAP_PC;
          freeze_d = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_CAP_PC: begin
        // PC index 0 needs only the ROM address, which is already zero.
        pc_d        = pc_i;
        iss_valid_d = 1'b1;
        iss_idx_d   = IDX_W'(IDX_PC);
        cnt_d       = '0;
        state_d     = ST_SCAN;
      end
      ST_SCAN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (iss_valid_q && iss_idx_q != IDX_W'(N - 1)) begin
          iss_valid_d = 1'b1;
          iss_idx_d   = iss_idx_q + IDX_W'(1);
          exp_addr_d  = iss_idx_d;
          if (iss_idx_d < IDX_W'(IDX_REG_BASE))
            mem_addr_d = MA_W'(iss_idx_d - IDX_W'(IDX_MEM_BASE));
          else
            reg_addr_d = RA_W'(iss_idx_d - IDX_W'(IDX_REG_BASE));
        end
        // Last index retires through read + compare + accumulate stages.
        if (cnt_q == CNT_W'(N + 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      freeze_q    <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      pc_q        <= '0;
      iss_valid_q <= 1'b0;
      iss_idx_q   <= '0;
      mem_addr_q  <= '0;
      reg_addr_q  <= '0;
      exp_addr_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      freeze_q    <= freeze_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      pc_q        <= pc_d;
      iss_valid_q <= iss_valid_d;
      iss_idx_q   <= iss_idx_d;
      mem_addr_q  <= mem_addr_d;
      reg_addr_q  <= reg_addr_d;
      exp_addr_q  <= exp_addr_d;
      rd_valid_q  <= iss_valid_q;
      rd_idx_q    <= iss_idx_q;
    end
  end

  always_comb begin
    if (rd_idx_q == IDX_W'(IDX_PC))
      actual = pc_q;
    else if (rd_idx_q < IDX_W'(IDX_REG_BASE))
      actual = mem_data_i;
    else
      actual = reg_data_i;
  end

  chk_err_accum #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .ERR_W  (ERR_W)
  ) u_accum (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .clear_i           (state_q == ST_IDLE),
    .valid_i           (rd_valid_q),
    .idx_i             (rd_idx_q),
    .actual_i          (actual),
    .expected_i        (exp_data_i),
    .err_count_o       (err_count_o),
    .first_err_valid_o (first_err_valid_o),
    .first_err_idx_o   (first_err_idx_o)
  );

  assign cpu_freeze_o = freeze_q;
  assign mem_addr_o   = mem_addr_q;
  assign reg_addr_o   = reg_addr_q;
  assign exp_addr_o   = exp_addr_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign pass_o       = done_q && !timeout_q && (err_count_o == '0);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cpu_halt_checker.sv
// Directed bench for cpu_halt_checker with a tiny CPU/PC model and
// synchronous memory, register-file and expected-ROM models.
module tb_cpu_halt_checker;
  import cpu_chk_pkg::*;

  localparam int MW = 4;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] instr;
  logic        freeze;
  logic [1:0]  mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  reg_addr;
  logic [31:0] reg_data;
  logic [3:0]  exp_addr;
  logic [31:0] exp_data;
  logic        done, pass, tmo, fev;
  logic [1:0]  err_cnt;
  logic [3:0]  fidx;
  chk_state_e  dbg_state;

  logic [31:0] mem  [MW];
  logic [31:0] regs [RC];
  logic [31:0] rom  [16];

  logic        cpu_clr = 1'b1;
  logic        cpu_run = 1'b0;
  logic        halt_en = 1'b0;
  logic [31:0] halt_pc = 32'h28;
  logic [31:0] cpu_pc  = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_halt_checker #(
    .DATA_W(32), .MEM_WORDS(MW), .REG_COUNT(RC),
    .HALT_INSTR(32'hFFFFFFFF), .TIMEOUT_CYC(20), .ERR_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_i(instr), .pc_i(cpu_pc),
    .cpu_freeze_o(freeze), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .reg_addr_o(reg_addr), .reg_data_i(reg_data), .exp_addr_o(exp_addr),
    .exp_data_i(exp_data), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .err_count_o(err_cnt), .first_err_valid_o(fev), .first_err_idx_o(fidx),
    .dbg_state_o(dbg_state)
  );

  // CPU model: PC advances by 4 per cycle unless frozen.
  always @(posedge clk) begin
    if (cpu_clr) cpu_pc <= 32'h0;
    else if (cpu_run && !freeze) cpu_pc <= cpu_pc + 32'd4;
  end
  assign instr = (halt_en && cpu_pc == halt_pc) ? 32'hFFFFFFFF : (32'h13 + cpu_pc);

  always @(posedge clk) begin
    mem_data <= mem[mem_addr];
    reg_data <= regs[reg_addr];
    exp_data <= rom[exp_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cpu_clr = 1'b1; cpu_run = 1'b0;
    tick(1);
    rst = 1'b0; cpu_clr = 1'b0;
  endtask

  task automatic fill_ok(input logic [31:0] pc_after);
    for (int i = 0; i < MW; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i * 3);
      rom[1 + i] = mem[i];
    end
    for (int i = 0; i < RC; i++) begin
      regs[i] = 32'h2000_0000 + 32'(i * 7);
      rom[1 + MW + i] = regs[i];
    end
    for (int i = 1 + MW + RC; i < 16; i++) rom[i] = 32'h0;
    rom[0] = pc_after;
  endtask

  task automatic launch();
    start = 1'b1; cpu_run = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (!done && k < max_cyc) begin
      tick(1);
      k++;
    end
    chk("done_reached", {31'h0, done}, 32'h1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {27'h0, done, pass, tmo, freeze, fev}, 32'h0);
    chk({tag, "_errcnt"}, {30'h0, err_cnt}, 32'h0);
    chk({tag, "_fidx"}, {28'h0, fidx}, 32'h0);
    chk({tag, "_addrs"}, {24'h0, mem_addr, reg_addr, exp_addr}, 32'h0);
  endtask

  initial begin
    bit mem_seen;

    // Reset state
    fill_ok(32'h2C);
    do_reset();
    check_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // Pass case: 10 instructions, halt at 0x28, PC after halt 0x2C
    halt_en = 1'b1; halt_pc = 32'h28;
    launch();
    tick(10);
    chk("pass_no_freeze_yet", {31'h0, freeze}, 32'h0);
    tick(1);
    chk("pass_freeze", {31'h0, freeze}, 32'h1);
    tick(11);
    chk("pass_done_not_early", {31'h0, done}, 32'h0);
    tick(1);
    chk("pass_done_on_time", {31'h0, done}, 32'h1);
    chk("pass_pass", {31'h0, pass}, 32'h1);
    chk("pass_errcnt", {30'h0, err_cnt}, 32'h0);
    chk("pass_timeout", {31'h0, tmo}, 32'h0);
    chk("pass_fev", {31'h0, fev}, 32'h0);
    chk("pass_state", 32'(dbg_state), 32'(ST_DONE));
    start = 1'b0;
    tick(3);
    chk("pass_hold", {29'h0, done, pass, freeze}, 32'h7);

    // Single error: memory[2]=5 vs expected 7
    fill_ok(32'h2C);
    mem[2] = 32'h5; rom[3] = 32'h7;
    do_reset();
    launch();
    wait_done(60);
    chk("single_errcnt", {30'h0, err_cnt}, 32'h1);
    chk("single_fidx", {28'h0, fidx}, 32'h3);
    chk("single_fev", {31'h0, fev}, 32'h1);
    chk("single_pass", {31'h0, pass}, 32'h0);

    // Saturation: PC and all four registers wrong, 2-bit counter
    fill_ok(32'h0);
    for (int i = 0; i < RC; i++) rom[1 + MW + i] = regs[i] ^ 32'h1;
    do_reset();
    launch();
    wait_done(60);
    chk("sat_errcnt", {30'h0, err_cnt}, 32'h3);
    chk("sat_fidx", {28'h0, fidx}, 32'h0);
    chk("sat_pass", {31'h0, pass}, 32'h0);

    // Timeout: no halt within 20 RUN cycles
    fill_ok(32'h2C);
    halt_en = 1'b0;
    do_reset();
    launch();
    mem_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mem_addr != 2'd0) mem_seen = 1'b1;
    end
    chk("tmo_done_not_early", {31'h0, done}, 32'h0);
    tick(1);
    chk("tmo_done", {31'h0, done}, 32'h1);
    chk("tmo_timeout", {31'h0, tmo}, 32'h1);
    chk("tmo_pass", {31'h0, pass}, 32'h0);
    chk("tmo_freeze", {31'h0, freeze}, 32'h0);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (mem_addr != 2'd0) mem_seen = 1'b1;
    end
    chk("tmo_mem_addr_idle", {31'h0, mem_seen}, 32'h0);
    chk("tmo_hold", {30'h0, done, tmo}, 32'h3);

    // Halt on the same edge as the timeout: halt wins
    fill_ok(32'h54);
    halt_en = 1'b1; halt_pc = 32'h50;
    do_reset();
    launch();
    tick(21);
    chk("tie_freeze", {31'h0, freeze}, 32'h1);
    chk("tie_timeout", {31'h0, tmo}, 32'h0);
    tick(11);
    chk("tie_done_not_early", {31'h0, done}, 32'h0);
    tick(1);
    chk("tie_done", {31'h0, done}, 32'h1);
    chk("tie_pass", {31'h0, pass}, 32'h1);

    // Reset mid-scan at idx 3 with a PC error already counted, then rerun
    fill_ok(32'hDEAD);
    halt_en = 1'b1; halt_pc = 32'h28;
    do_reset();
    launch();
    tick(15);
    chk("mid_exp_addr", {28'h0, exp_addr}, 32'h3);
    chk("mid_mem_addr", {30'h0, mem_addr}, 32'h2);
    chk("mid_errcnt", {30'h0, err_cnt}, 32'h1);
    do_reset();
    check_zero("mid_reset");
    rom[0] = 32'h2C;
    launch();
    wait_done(60);
    chk("rerun_errcnt", {30'h0, err_cnt}, 32'h0);
    chk("rerun_fev", {31'h0, fev}, 32'h0);
    chk("rerun_pass", {31'h0, pass}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
